step_move_sequencer: RTL and testbench

Move-level controller for the stepper datapath. Accepts a move command (step count, direction, peak speed level 1..7) over a valid/ready handshake and emits single-cycle step pulses with a linear speed-level ramp up and ramp down. Sits between the user/command logic and the driver controller: step_pulse and dir_out feed the driver, and cur_speed feeds the speed display. Replaces the free-running fixed-speed pulse source for positioned moves.

---
 rtl/step_move_sequencer.sv | 164 ++++++++++++++++
 tb/tb_step_move_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_move_sequencer.sv
// Move-level stepper controller: accepts a move command and emits step pulses with a linear
// speed-level ramp. Define STEP_POS_COUNTER_EN to add the absolute position output.
module step_move_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned BASE_PERIOD = 5000000,
  parameter int unsigned RAMP_STEPS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [2:0]       cmd_speed,
  input  logic             abort,
  output logic             step_pulse,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       cur_speed,
  output logic [CNT_W-1:0] steps_left
`ifdef STEP_POS_COUNTER_EN
  ,
  output logic [CNT_W:0]   position
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_CRUISE = 3'd2;
  localparam logic [2:0] S_DECEL  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam int unsigned RW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEPS - 1);

  logic [2:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       lvl_q, lvl_d;
  logic [RW-1:0]    ramp_q, ramp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             abort_q, abort_d;

  logic [CNT_W-1:0] steps_dec;
  logic [31:0]      decel_thr;
  logic [2:0]       lvl_n;

  // Counter reload value: period(L) - 1, clamped so a tiny BASE_PERIOD still gives >= 1 cycle.
  function automatic logic [DIV_W-1:0] reload(input logic [2:0] lvl);
    logic [DIV_W-1:0] p;
    p = DIV_W'(BASE_PERIOD >> (lvl - 3'd1));
    if (p == '0) p = DIV_W'(1);
    return p - DIV_W'(1);
  endfunction

  assign busy       = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
  assign step_pulse = busy && (div_q == '0);
  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign aborted    = (state_q == S_FINISH) && abort_q;
  assign cur_speed  = busy ? lvl_q : 3'd0;
  assign dir_out    = dir_q;
  assign steps_left = steps_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    steps_d   = steps_q;
    tgt_d     = tgt_q;
    lvl_d     = lvl_q;
    ramp_d    = ramp_q;
    div_d     = div_q;
    abort_d   = abort_q | (abort & busy);
    steps_dec = (steps_q == '0) ? '0 : steps_q - CNT_W'(1);
    decel_thr = (32'(lvl_q) - 32'd1) * 32'(RAMP_STEPS);
    lvl_n     = lvl_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          tgt_d   = (cmd_speed == 3'd0) ? 3'd1 : cmd_speed;
          lvl_d   = 3'd1;
          ramp_d  = '0;
          abort_d = 1'b0;
          div_d   = '0;
          state_d = (cmd_steps == '0) ? S_FINISH : S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (step_pulse) begin
          steps_d = steps_dec;
          if (steps_dec == '0) begin
            // Final step takes priority: an abort seen in this same cycle is not reported.
            state_d = S_FINISH;
            abort_d = abort_q;
          end else if (abort_q && (lvl_q == 3'd1)) begin
            state_d = S_FINISH;
          end else if ((state_q != S_DECEL) && (abort_q || (32'(steps_dec) <= decel_thr))) begin
            state_d = S_DECEL;
            ramp_d  = '0;
            div_d   = reload(lvl_q);
          end else begin
            if (ramp_q == RAMP_LAST) begin
              ramp_d = '0;
              if ((state_q == S_ACCEL) && (lvl_q < tgt_q)) lvl_n = lvl_q + 3'd1;
              else if ((state_q == S_DECEL) && (lvl_q > 3'd1)) lvl_n = lvl_q - 3'd1;
            end else begin
              ramp_d = ramp_q + RW'(1);
            end
            lvl_d = lvl_n;
            div_d = reload(lvl_n);
            if ((state_q == S_ACCEL) && (lvl_n == tgt_q)) state_d = S_CRUISE;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      steps_q <= '0;
      tgt_q   <= '0;
      lvl_q   <= '0;
      ramp_q  <= '0;
      div_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      tgt_q   <= tgt_d;
      lvl_q   <= lvl_d;
      ramp_q  <= ramp_d;
      div_q   <= div_d;
      abort_q <= abort_d;
    end
  end

`ifdef STEP_POS_COUNTER_EN
  logic [CNT_W:0] pos_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= '0;
    end else if (step_pulse) begin
      pos_q <= dir_q ? pos_q + (CNT_W+1)'(1) : pos_q - (CNT_W+1)'(1);
    end
  end

  assign position = pos_q;
`endif

endmodule

// File: tb/tb_step_move_sequencer.sv
// Self-checking bench for step_move_sequencer: directed and random moves against a per-step
// reference model of the ramp rules (BASE_PERIOD=64, RAMP_STEPS=2).
module tb_step_move_sequencer;
  localparam int CNT_W = 16;
  localparam int BASE  = 64;
  localparam int RAMP  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [2:0]       cmd_speed;
  logic             abort;
  logic             step_pulse;
  logic             dir_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [2:0]       cur_speed;
  logic [CNT_W-1:0] steps_left;
`ifdef STEP_POS_COUNTER_EN
  logic [CNT_W:0]   position;
  logic [CNT_W:0]   exp_pos;
`endif

  int errors = 0;
  int checks = 0;

  int exp_t[$];
  int exp_l[$];
  int exp_done;
  int exp_left;
  bit exp_ab;

  step_move_sequencer #(
    .CNT_W(CNT_W),
    .DIV_W(24),
    .BASE_PERIOD(BASE),
    .RAMP_STEPS(RAMP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir),
    .cmd_speed(cmd_speed),
    .abort(abort),
    .step_pulse(step_pulse),
    .dir_out(dir_out),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .cur_speed(cur_speed),
    .steps_left(steps_left)
`ifdef STEP_POS_COUNTER_EN
    ,
    .position(position)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Walks the move one step at a time: pulse times (cycles after accept), level at each pulse,
  // done cycle, abort outcome and residual step count.
  function automatic void build_model(input int steps, input int spd, input int ab);
    int lvl, tgt, rc, rem, t;
    bit decel, cruise, flag;
    exp_t.delete();
    exp_l.delete();
    lvl = 1; tgt = (spd == 0) ? 1 : spd; rc = 0; rem = steps; t = 1;
    decel = 0; cruise = 0; exp_ab = 0;
    if (steps == 0) begin
      exp_done = 1;
      exp_left = 0;
      return;
    end
    forever begin
      flag = (ab > 0) && (ab < t);
      exp_t.push_back(t);
      exp_l.push_back(lvl);
      rem--;
      if (rem == 0) begin exp_ab = flag; break; end
      if (flag && lvl == 1) begin exp_ab = 1; break; end
      if (!decel && (flag || rem <= (lvl - 1) * RAMP)) begin
        decel = 1;
        rc = 0;
      end else begin
        if (rc == RAMP - 1) begin
          rc = 0;
          if (decel) lvl = (lvl > 1) ? lvl - 1 : 1;
          else if (!cruise && lvl < tgt) lvl++;
        end else begin
          rc++;
        end
        if (!decel && lvl == tgt) cruise = 1;
      end
      t += BASE >> (lvl - 1);
    end
    exp_done = t + 1;
    exp_left = rem;
  endfunction

  // Issues one command and checks every cycle until the expected done cycle.
  task automatic run_move(input int steps, input int spd, input bit dir, input int ab,
                          input bit hold);
    int rel, idx;
    bit fin, exp_p;
    @(negedge clk);
    cmd_steps = CNT_W'(steps);
    cmd_speed = 3'(spd);
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    chk(cmd_ready, 1, "ready_before_accept");
    build_model(steps, spd, ab);
    @(posedge clk);
    rel = 0; idx = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      rel++;
      if (!hold) cmd_valid = 1'b0;
      exp_p = (idx < exp_t.size()) && (exp_t[idx] == rel);
      chk(step_pulse, exp_p, "step_pulse");
      if (exp_p) begin
        chk(cur_speed, exp_l[idx], "cur_speed_at_pulse");
        chk(dir_out, dir, "dir_out");
`ifdef STEP_POS_COUNTER_EN
        exp_pos = dir ? exp_pos + 1'b1 : exp_pos - 1'b1;
`endif
        idx++;
      end
      chk(busy, rel < exp_done, "busy");
      chk(done, rel == exp_done, "done");
      chk(cmd_ready, 0, "ready_during_move");
      if (rel == exp_done) begin
        chk(aborted, exp_ab, "aborted");
        chk(steps_left, exp_left, "steps_left_end");
        chk(cur_speed, 0, "cur_speed_finish");
`ifdef STEP_POS_COUNTER_EN
        chk(position, exp_pos, "position");
`endif
        fin = 1;
      end
      abort = (rel == ab);
    end
    abort = 1'b0;
  endtask

  initial begin
    int found;
    rst = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_speed = 3'd0; abort = 1'b0;
`ifdef STEP_POS_COUNTER_EN
    exp_pos = '0;
`endif
    repeat (3) @(negedge clk);
    chk(cmd_ready, 1, "rst_cmd_ready");
    chk(busy, 0, "rst_busy");
    chk(done, 0, "rst_done");
    chk(step_pulse, 0, "rst_step_pulse");
    chk(cur_speed, 0, "rst_cur_speed");
    chk(steps_left, 0, "rst_steps_left");
    chk(dir_out, 0, "rst_dir_out");
    rst = 1'b1;

    run_move(10, 3, 1'b1, 0, 1'b0);
    run_move(100, 1, 1'b0, 10, 1'b0);
    run_move(0, 5, 1'b1, 0, 1'b0);
    run_move(12, 2, 1'b0, 0, 1'b1);
    run_move(5, 7, 1'b1, 0, 1'b0);
    run_move(20, 3, 1'b1, 30, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int s, sp, ab;
      s  = int'($urandom_range(0, 30));
      sp = int'($urandom_range(0, 7));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 400)) : 0;
      run_move(s, sp, 1'($urandom_range(0, 1)), ab, 1'b0);
    end

    // Asynchronous reset landing mid-cycle while cruising at level 3.
    @(negedge clk);
    cmd_steps = CNT_W'(20); cmd_speed = 3'd3; cmd_dir = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (step_pulse && cur_speed == 3'd3) found = 1;
    end
    chk(found, 1, "reach_cruise");
    #2 rst = 1'b0;
    #1;
    chk(step_pulse, 0, "async_rst_step_pulse");
    chk(busy, 0, "async_rst_busy");
    chk(cur_speed, 0, "async_rst_cur_speed");
    chk(done, 0, "async_rst_done");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk(done, 0, "no_done_in_reset");
    end
    rst = 1'b1;
    @(negedge clk);
    chk(cmd_ready, 1, "ready_after_rst");
    chk(done, 0, "no_done_after_rst");
`ifdef STEP_POS_COUNTER_EN
    exp_pos = '0;
    chk(position, 0, "position_after_rst");
    run_move(10, 3, 1'b1, 0, 1'b0);
    run_move(3, 2, 1'b0, 0, 1'b0);
    chk(position, 7, "position_plus7");
    run_move(8, 4, 1'b0, 0, 1'b0);
    chk(position, 32'h1FFFF, "position_minus1");
`endif
    run_move(7, 2, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
